mul_div_unit: RTL and testbench



---
 rtl/md_pkg.sv | 23 ++
 rtl/mul_div_unit_core.sv | 54 +++++
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_core.sv
// Shared accumulator datapath: one shift-add multiply step or one
// restoring shift-subtract divide step per enabled cycle.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] res
);

  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_nx;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   diff;

  // Multiply: {carry, hi} += b when lsb set, then shift right.
  // Divide: {rem, quot} shifts left; subtract divisor when it fits.
  always_comb begin
    msum = acc[2*WIDTH:WIDTH];
    if (acc[0])
      msum = acc[2*WIDTH:WIDTH] + {1'b0, b_q};
    rsh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rsh - {1'b0, b_q};
    acc_nx = {1'b0, msum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH])
        acc_nx = {rsh, acc[WIDTH-2:0], 1'b0};
      else
        acc_nx = {diff, acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      b_q <= '0;
    end else if (load) begin
      acc <= {{(WIDTH+1){1'b0}}, a_in};
      b_q <= b_in;
    end else if (step) begin
      acc <= acc_nx;
    end
  end

  assign res = acc[2*WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage iterative mult/div unit owning the HI/LO registers.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  input  logic             mf_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             md_stall
);

  localparam int CW = $clog2(ITERS) + 1;

  md_state_e state, state_nx;

  logic [CW-1:0]      cnt;
  logic               is_div, q_neg, r_neg, div0;
  logic [WIDTH-1:0]   a_raw;
  logic               go_md, go_sgn, go_div;
  logic               wr_hi, wr_lo;
  logic               last, step, fin;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] res, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               issue;

  assign issue = start && !cancel && (state == IDLE);

  always_comb begin
    go_md  = 1'b0;
    go_sgn = 1'b0;
    go_div = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    if (issue) begin
      unique case (1'b1)
        md_op == MULT: begin
          go_md = 1'b1; go_sgn = 1'b1;
        end
        md_op == MULTU: go_md = 1'b1;
        md_op == DIV: begin
          go_md = 1'b1; go_sgn = 1'b1;
          go_div = 1'b1;
        end
        md_op == DIVU: begin
          go_md = 1'b1; go_div = 1'b1;
        end
        md_op == MTHI: wr_hi = 1'b1;
        md_op == MTLO: wr_lo = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    a_mag = operand_a;
    b_mag = operand_b;
    if (go_sgn && operand_a[WIDTH-1])
      a_mag = -operand_a;
    if (go_sgn && operand_b[WIDTH-1])
      b_mag = -operand_b;
  end

  assign last = (cnt == CW'(ITERS - 1));
  assign step = (state == CALC) && !cancel;
  assign fin  = (state == FIX) && !cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go_md) state_nx = CALC;
      CALC: begin
        if (cancel)    state_nx = IDLE;
        else if (last) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
    end else if (go_md) begin
      cnt    <= '0;
      is_div <= go_div;
      q_neg  <= go_sgn &&
                (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      r_neg  <= go_sgn && operand_a[WIDTH-1];
      div0   <= go_div && (operand_b == '0);
      a_raw  <= operand_a;
    end else if (step) begin
      cnt <= cnt + CW'(1);
    end
  end

  md_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (go_md),
    .step   (step),
    .is_div (is_div),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .res    (res)
  );

  // Product and quotient share the result-sign flag; remainder
  // follows the dividend.
  always_comb begin
    prod   = q_neg ? -res : res;
    quo    = q_neg ? -res[WIDTH-1:0] : res[WIDTH-1:0];
    rem    = r_neg ? -res[2*WIDTH-1:WIDTH]
                   : res[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = a_raw;
        res_lo = WIDTH'(DIV0_QUOT);
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (wr_hi) hi <= operand_a;
      if (wr_lo) lo <= operand_a;
      if (fin) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign md_stall = busy && (start || mf_read);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        cancel = 1'b0;
  logic        mf_read = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, md_stall;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .md_op     (md_op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .cancel    (cancel),
    .mf_read   (mf_read),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .md_stall  (md_stall)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op;
    operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; md_op = NOP;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input bit mf,
                        input bit poke);
    int n;
    issue(op, a, b);
    mf_read = mf;
    if (mf) chk({tag, "_stall"}, 32'(md_stall), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (poke && n == 5) begin
        start = 1'b1; md_op = MTHI;
        operand_a = 32'hDEADBEEF;
      end else begin
        start = 1'b0; md_op = NOP;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cyc"}, 32'(n), 32'd33);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_nostall"}, 32'(md_stall), 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    mf_read = 1'b0;
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;
    #12;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    run_op("mult", MULT, 32'hFFFFFFFD, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    run_op("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    run_op("div", DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    run_op("divu0", DIVU, 32'd100, 32'd0,
           32'h00000064, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("divovf", DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op("divneg", DIV, 32'd7, 32'hFFFFFFFE,
           32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; md_op = MTHI; operand_a = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'd0);
    md_op = MTLO; operand_a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0; md_op = NOP;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mt_busy", 32'(busy), 32'd0);
    chk("mt_done", 32'(done), 32'd0);

    // cancel together with start in IDLE
    start = 1'b1; cancel = 1'b1; md_op = MTHI;
    operand_a = 32'h55555555;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; md_op = NOP;
    chk("cxl_mthi_hi", hi, 32'h12345678);
    start = 1'b1; cancel = 1'b1; md_op = MULT;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cxl_mult_busy", 32'(busy), 32'd0);

    // invalid opcode is a NOP
    start = 1'b1; md_op = 3'd7; operand_a = 32'h1;
    @(negedge clk);
    start = 1'b0; md_op = NOP;
    chk("inv_busy", 32'(busy), 32'd0);
    chk("inv_hi", hi, 32'h12345678);

    // cancel mid-flight
    issue(MULT, 32'd3, 32'd5);
    repeat (8) @(negedge clk);
    chk("cxl_pre_busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl_busy", 32'(busy), 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("cxl_nodone", 32'(dn), 32'd0);
    chk("cxl_hi", hi, 32'h12345678);
    chk("cxl_lo", lo, 32'h9ABCDEF0);

    // asynchronous reset mid-CALC
    issue(MULT, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post", MULTU, 32'd6, 32'd7,
           32'd0, 32'd42, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
